// File: rtl/encoder_event_ctrl_if.sv
// Event-stream handshake between the encoder controller and the CPU side.
// The controller presents the FIFO head; the consumer answers with ready.
interface encoder_event_ctrl_if;
    logic       ev_valid;
    logic       ev_ready;
    logic [2:0] ev_code;
    logic [2:0] ev_count;

    modport master (output ev_valid, output ev_code, output ev_count, input  ev_ready);
    modport slave  (input  ev_valid, input  ev_code, input  ev_count, output ev_ready);
endinterface

// File: rtl/encoder_event_ctrl.sv
// Turns encoder detents into a saturating, accelerated position and queues
// rotation / short-press / long-press events in a 4-deep FWFT FIFO.
module encoder_event_ctrl #(
    parameter int unsigned POS_WIDTH   = 8,
    parameter int unsigned POS_MIN     = 0,
    parameter int unsigned POS_MAX     = 255,
    parameter int unsigned FAST_STEP   = 4,
    parameter int unsigned FAST_WINDOW = 2500000,
    parameter int unsigned LONG_PRESS  = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enc_state_change_stb,
    input  logic                 clockwise,
    input  logic                 click,
    input  logic                 switch,
    input  logic                 pos_load,
    input  logic [POS_WIDTH-1:0] pos_load_value,
    input  logic                 ovf_clear,
    output logic [POS_WIDTH-1:0] position,
    output logic                 overflow,
    output logic                 pressed_long,
    encoder_event_ctrl_if.master ev
);

    localparam int unsigned EXT_W  = POS_WIDTH + 1;
    localparam int unsigned WIN_W  = $clog2(FAST_WINDOW + 1);
    localparam int unsigned LP_W   = $clog2(LONG_PRESS + 1);
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PTR_W  = 2;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0]    EV_CW    = CODE_W'(1);
    localparam logic [CODE_W-1:0]    EV_CCW   = CODE_W'(2);
    localparam logic [CODE_W-1:0]    EV_SHORT = CODE_W'(3);
    localparam logic [CODE_W-1:0]    EV_LONG  = CODE_W'(4);
    localparam logic [EXT_W-1:0]     MIN_X    = EXT_W'(POS_MIN);
    localparam logic [EXT_W-1:0]     MAX_X    = EXT_W'(POS_MAX);
    localparam logic [EXT_W-1:0]     ONE_X    = EXT_W'(1);
    localparam logic [EXT_W-1:0]     FAST_X   = EXT_W'(FAST_STEP);
    localparam logic [POS_WIDTH-1:0] MIN_P    = POS_WIDTH'(POS_MIN);
    localparam logic [POS_WIDTH-1:0] MAX_P    = POS_WIDTH'(POS_MAX);
    localparam logic [WIN_W-1:0]     WIN_SAT  = WIN_W'(FAST_WINDOW);
    localparam logic [LP_W-1:0]      LP_LAST  = LP_W'(LONG_PRESS - 1);

    typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} press_state_t;

    press_state_t        state_q, state_n;
    logic [LP_W-1:0]     press_cnt_q, press_cnt_n;
    logic                arm_q, arm_n;
    logic                prs_vld_q, prs_vld_n;
    logic [CODE_W-1:0]   prs_code_q, prs_code_n;
    logic                click_d;
    logic [WIN_W-1:0]    win_cnt_q, win_cnt_n;
    logic                last_dir_q, last_dir_n;
    logic                rot_vld_q, rot_vld_n;
    logic                rot_dir_q, rot_dir_n;
    logic                rot_fast_q, rot_fast_n;
    logic                pend_vld_q, pend_vld_n;
    logic [CODE_W-1:0]   pend_code_q, pend_code_n;
    logic [CODE_W-1:0]   mem_q [DEPTH];
    logic [CODE_W-1:0]   mem_n [DEPTH];
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_n, wr_ptr_q, wr_ptr_n;
    logic [CNT_W-1:0]    count_q, count_n;
    logic                ev_valid_q, ev_valid_n;
    logic [CODE_W-1:0]   ev_code_q, ev_code_n;
    logic [POS_WIDTH-1:0] position_q, position_n;
    logic                overflow_q, overflow_n;
    logic                pressed_long_q, pressed_long_n;

    logic                detent;
    logic [EXT_W-1:0]    step, pos_ext, load_ext, sum;
    logic                push, displaced, pop, full, push_ok, drop;
    logic [CODE_W-1:0]   push_code;

    assign position     = position_q;
    assign overflow     = overflow_q;
    assign pressed_long = pressed_long_q;
    assign ev.ev_valid  = ev_valid_q;
    assign ev.ev_code   = ev_code_q;
    assign ev.ev_count  = count_q;

    // State register: every flop of the block lives here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            press_cnt_q    <= '0;
            arm_q          <= 1'b0;
            prs_vld_q      <= 1'b0;
            prs_code_q     <= '0;
            click_d        <= 1'b0;
            win_cnt_q      <= WIN_SAT;
            last_dir_q     <= 1'b0;
            rot_vld_q      <= 1'b0;
            rot_dir_q      <= 1'b0;
            rot_fast_q     <= 1'b0;
            pend_vld_q     <= 1'b0;
            pend_code_q    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            ev_valid_q     <= 1'b0;
            ev_code_q      <= '0;
            position_q     <= MIN_P;
            overflow_q     <= 1'b0;
            pressed_long_q <= 1'b0;
        end else begin
            state_q        <= state_n;
            press_cnt_q    <= press_cnt_n;
            arm_q          <= arm_n;
            prs_vld_q      <= prs_vld_n;
            prs_code_q     <= prs_code_n;
            click_d        <= click;
            win_cnt_q      <= win_cnt_n;
            last_dir_q     <= last_dir_n;
            rot_vld_q      <= rot_vld_n;
            rot_dir_q      <= rot_dir_n;
            rot_fast_q     <= rot_fast_n;
            pend_vld_q     <= pend_vld_n;
            pend_code_q    <= pend_code_n;
            mem_q          <= mem_n;
            rd_ptr_q       <= rd_ptr_n;
            wr_ptr_q       <= wr_ptr_n;
            count_q        <= count_n;
            ev_valid_q     <= ev_valid_n;
            ev_code_q      <= ev_code_n;
            position_q     <= position_n;
            overflow_q     <= overflow_n;
            pressed_long_q <= pressed_long_n;
        end
    end

    // Next-state logic: detent/acceleration, press FSM, position, event arbitration, FIFO.
    always_comb begin
        state_n     = state_q;
        press_cnt_n = press_cnt_q;
        arm_n       = arm_q | ~switch;
        prs_vld_n   = 1'b0;
        prs_code_n  = prs_code_q;
        win_cnt_n   = (win_cnt_q == WIN_SAT) ? win_cnt_q : win_cnt_q + WIN_W'(1);
        last_dir_n  = last_dir_q;
        detent      = enc_state_change_stb & click & ~click_d;
        rot_vld_n   = detent;
        rot_dir_n   = clockwise;
        rot_fast_n  = (win_cnt_q < WIN_SAT) && (clockwise == last_dir_q);
        step        = rot_fast_q ? FAST_X : ONE_X;
        pos_ext     = EXT_W'(position_q);
        load_ext    = EXT_W'(pos_load_value);
        sum         = pos_ext + step;
        position_n  = position_q;
        push        = 1'b0;
        push_code   = '0;
        displaced   = 1'b0;
        pend_vld_n  = 1'b0;
        pend_code_n = pend_code_q;
        pop         = ev_valid_q & ev.ev_ready;
        full        = (count_q == CNT_W'(DEPTH));
        mem_n       = mem_q;

        if (detent) begin
            win_cnt_n  = '0;
            last_dir_n = clockwise;
        end

        // A press held through reset must be released once before it can count.
        unique case (state_q)
            IDLE: begin
                if (switch && arm_q) begin
                    state_n     = PRESSED;
                    press_cnt_n = '0;
                end
            end
            PRESSED: begin
                if (!switch) begin
                    state_n    = IDLE;
                    prs_vld_n  = 1'b1;
                    prs_code_n = EV_SHORT;
                end else if (press_cnt_q == LP_LAST) begin
                    state_n    = LONG_HELD;
                    prs_vld_n  = 1'b1;
                    prs_code_n = EV_LONG;
                end else begin
                    press_cnt_n = press_cnt_q + LP_W'(1);
                end
            end
            LONG_HELD: begin
                if (!switch) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (pos_load) begin
            if (load_ext + ONE_X < MIN_X + ONE_X) position_n = MIN_P;
            else if (load_ext > MAX_X)            position_n = MAX_P;
            else                                  position_n = pos_load_value;
        end else if (rot_vld_q) begin
            if (rot_dir_q) position_n = (sum > MAX_X) ? MAX_P : POS_WIDTH'(sum);
            else           position_n = (pos_ext < MIN_X + step) ? MIN_P : POS_WIDTH'(pos_ext - step);
        end

        // One push per cycle: pending press first, then rotation, then press.
        if (pend_vld_q) begin
            push      = 1'b1;
            push_code = pend_code_q;
            displaced = rot_vld_q | prs_vld_q;
        end else if (rot_vld_q) begin
            push      = 1'b1;
            push_code = rot_dir_q ? EV_CW : EV_CCW;
            if (prs_vld_q) begin
                pend_vld_n  = 1'b1;
                pend_code_n = prs_code_q;
            end
        end else if (prs_vld_q) begin
            push      = 1'b1;
            push_code = prs_code_q;
        end

        push_ok = push & (~full | pop);
        drop    = push & full & ~pop;
        if (push_ok) mem_n[wr_ptr_q] = push_code;
        wr_ptr_n = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_n = rd_ptr_q + PTR_W'(pop);
        count_n  = count_q + CNT_W'(push_ok) - CNT_W'(pop);

        ev_valid_n     = (count_n != '0);
        ev_code_n      = ev_valid_n ? mem_n[rd_ptr_n] : '0;
        overflow_n     = (drop | displaced) ? 1'b1 : (ovf_clear ? 1'b0 : overflow_q);
        pressed_long_n = (state_n == LONG_HELD);
    end

endmodule

// File: tb/tb_encoder_event_ctrl.sv
// Randomized and directed bench for encoder_event_ctrl, checked every cycle
// against a queue-based behavioural model.
module tb_encoder_event_ctrl;
    localparam int PW = 9, PMIN = 0, PMAX = 255, FS = 4, FW = 100, LP = 1000;

    logic clk = 1'b0, reset = 1'b0;
    logic stb = 0, cw = 0, click = 0, sw = 0, pos_load = 0, ovf_clear = 0, ready = 0;
    logic [PW-1:0] pos_val = '0;
    logic [PW-1:0] position;
    logic overflow, pressed_long;

    encoder_event_ctrl_if ev_if();
    assign ev_if.ev_ready = ready;

    encoder_event_ctrl #(.POS_WIDTH(PW), .POS_MIN(PMIN), .POS_MAX(PMAX), .FAST_STEP(FS),
                         .FAST_WINDOW(FW), .LONG_PRESS(LP)) dut (
        .clk(clk), .reset(reset), .enc_state_change_stb(stb), .clockwise(cw), .click(click),
        .switch(sw), .pos_load(pos_load), .pos_load_value(pos_val), .ovf_clear(ovf_clear),
        .position(position), .overflow(overflow), .pressed_long(pressed_long), .ev(ev_if));

    always #5 clk = ~clk;

    // Behavioural model state
    int     m_pos, mq[$], m_hold, m_rot_step, m_prs_c, m_pend_c;
    bit     m_ovf, m_armed, m_prev_click, m_last_dir, m_rot_v, m_rot_dir, m_prs_v, m_pend_v;
    longint m_cyc, m_last_det;
    int     n_checks = 0, n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 25) $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        return (v < PMIN) ? PMIN : ((v > PMAX) ? PMAX : v);
    endfunction

    task automatic model_reset();
        m_pos = PMIN; mq.delete(); m_ovf = 0; m_hold = 0; m_armed = 0; m_prev_click = 0;
        m_last_det = -1000000; m_last_dir = 0; m_rot_v = 0; m_prs_v = 0; m_pend_v = 0;
        m_rot_dir = 0; m_rot_step = 1; m_prs_c = 0; m_pend_c = 0; m_cyc = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        int cand[$];
        bit drop = 0, new_pend_v = 0, detent;
        int new_pend_c = 0;
        if (mq.size() > 0 && ready) void'(mq.pop_front());
        if (m_pend_v) begin
            cand.push_back(m_pend_c);
            if (m_rot_v || m_prs_v) drop = 1;
        end else begin
            if (m_rot_v) cand.push_back(m_rot_dir ? 1 : 2);
            if (m_prs_v) begin
                if (m_rot_v) begin new_pend_v = 1; new_pend_c = m_prs_c; end
                else cand.push_back(m_prs_c);
            end
        end
        foreach (cand[i]) begin
            if (mq.size() < 4) mq.push_back(cand[i]);
            else drop = 1;
        end
        m_pend_v = new_pend_v; m_pend_c = new_pend_c;
        if (drop) m_ovf = 1; else if (ovf_clear) m_ovf = 0;
        if (pos_load) m_pos = clamp(int'(pos_val));
        else if (m_rot_v) m_pos = clamp(m_rot_dir ? m_pos + m_rot_step : m_pos - m_rot_step);

        detent = stb && click && !m_prev_click;
        m_prev_click = click;
        m_rot_v = 0;
        if (detent) begin
            m_rot_v    = 1;
            m_rot_dir  = cw;
            m_rot_step = ((m_cyc - m_last_det <= FW) && (cw == m_last_dir)) ? FS : 1;
            m_last_det = m_cyc;
            m_last_dir = cw;
        end
        m_prs_v = 0;
        if (sw) begin
            if (m_hold > 0 || m_armed) begin
                if (m_hold == LP) begin m_prs_v = 1; m_prs_c = 4; end
                m_hold++;
            end
        end else begin
            if (m_hold > 0 && m_hold <= LP) begin m_prs_v = 1; m_prs_c = 3; end
            m_hold  = 0;
            m_armed = 1;
        end
        m_cyc++;
    endtask

    task automatic check_outputs();
        check_eq("position", position, m_pos);
        check_eq("ev_valid", ev_if.ev_valid, mq.size() > 0);
        check_eq("ev_code", ev_if.ev_code, (mq.size() > 0) ? mq[0] : 0);
        check_eq("ev_count", ev_if.ev_count, mq.size());
        check_eq("overflow", overflow, m_ovf);
        check_eq("pressed_long", pressed_long, m_hold > LP);
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic detent(input bit dir);
        stb = 1; click = 1; cw = dir; step();
        stb = 0; click = 0; step();
    endtask

    task automatic drain();
        ready = 1; idle(6); ready = 0;
    endtask

    initial begin
        int sw_timer;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1;

        // Slow CW detents: step 1 each, latency of two cycles from strobe
        stb = 1; click = 1; cw = 1; step();
        check_eq("latency_c1", ev_if.ev_valid, 0);
        stb = 0; click = 0; step();
        check_eq("latency_c2", ev_if.ev_valid, 1);
        idle(1000); detent(1); idle(1000); detent(1); idle(5);
        check_eq("slow_pos", position, 3);
        check_eq("slow_count", ev_if.ev_count, 3);
        check_eq("slow_code", ev_if.ev_code, 1);
        drain();

        // Acceleration and saturation
        pos_load = 1; pos_val = 250; step(); pos_load = 0;
        check_eq("load_250", position, 250);
        idle(200);
        detent(1); check_eq("acc_pos1", position, 251); idle(18);
        detent(1); check_eq("acc_pos2", position, 255); idle(18);
        detent(1); check_eq("acc_pos3", position, 255);
        pos_load = 1; pos_val = 0; step(); pos_load = 0;
        detent(0);
        check_eq("ccw_floor", position, 0);
        check_eq("ccw_count", ev_if.ev_count, 4);
        drain();

        // Short then long press
        sw = 1; idle(500); sw = 0; idle(3);
        check_eq("short_code", ev_if.ev_code, 3);
        check_eq("short_count", ev_if.ev_count, 1);
        drain();
        sw = 1; idle(1000);
        check_eq("long_early", ev_if.ev_count, 0);
        step();
        check_eq("long_held", pressed_long, 1);
        step();
        check_eq("long_code", ev_if.ev_code, 4);
        idle(498); sw = 0; step();
        check_eq("long_release", pressed_long, 0);
        idle(5);
        check_eq("long_single", ev_if.ev_count, 1);
        drain();

        // Overflow, clear, ordered drain
        for (int i = 0; i < 5; i++) begin detent(1'($urandom)); idle(3); end
        check_eq("ovf_count", ev_if.ev_count, 4);
        check_eq("ovf_set", overflow, 1);
        ovf_clear = 1; step(); ovf_clear = 0;
        check_eq("ovf_clear", overflow, 0);
        ready = 1; idle(4);
        check_eq("drain_empty", ev_if.ev_valid, 0);
        ready = 0; idle(2);

        // Detent coincident with short-press release
        sw = 1; idle(50);
        stb = 1; click = 1; cw = 1; sw = 0; step();
        stb = 0; click = 0; step();
        check_eq("coin_first", ev_if.ev_code, 1);
        step();
        check_eq("coin_count", ev_if.ev_count, 2);
        ready = 1; step(); ready = 0;
        check_eq("coin_second", ev_if.ev_code, 3);
        drain();
        pos_load = 1; pos_val = 300; step(); pos_load = 0;
        check_eq("load_clamp", position, 255);

        // Reset in the middle of a long press
        sw = 1; idle(800);
        reset = 0; #1;
        model_reset();
        check_outputs();
        check_eq("rst_pos", position, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        idle(20); sw = 0; idle(1100);
        check_eq("rst_no_event", ev_if.ev_count, 0);

        // Randomized traffic
        sw_timer = 0;
        for (int c = 0; c < 20000; c++) begin
            stb       = ($urandom % 6) == 0;
            click     = 1'($urandom);
            cw        = 1'($urandom);
            ready     = ((c / 400) % 2 == 0) ? (($urandom % 3) == 0) : 1'b0;
            ovf_clear = ($urandom % 60) == 0;
            pos_load  = ($urandom % 300) == 0;
            pos_val   = PW'($urandom);
            if (sw_timer == 0) begin
                sw = ~sw;
                sw_timer = $urandom_range(1, 1300);
            end else sw_timer--;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
